seq_shifter: RTL and testbench

Multi-cycle, parametrised shift/rotate unit that is the sequential successor to the lab's single-position combinational shifter chain. It shifts by a runtime amount `B` instead of a fixed build-time amount, at up to `STEP` positions per clock. It supports logical, arithmetic and rotate modes in both directions. It sits beside the ALU datapath behind a start/busy/done handshake, so wide shifts do not lengthen the combinational critical path.

---
 rtl/seq_shifter_if.sv | 29 ++
 rtl/seq_shifter.sv | 114 +++++++++++
 tb/tb_seq_shifter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter_if
// Brief    : Request/result bundle for the sequential shift/rotate unit.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_shifter_if #(
    parameter int N = 8
);
    logic                 start;
    logic [N-1:0]         A;
    logic [$clog2(N)-1:0] B;
    logic [1:0]           mode;
    logic                 dir;
    logic [N-1:0]         Aout;
    logic                 busy;
    logic                 done;

    modport master (
        output start, A, B, mode, dir,
        input  Aout, busy, done
    );

    modport slave (
        input  start, A, B, mode, dir,
        output Aout, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Brief    : Multi-cycle shift/rotate by a runtime amount, up to STEP bits/clk.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shifter #(
    parameter int N    = 8,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    seq_shifter_if.slave  bus
);
    localparam int             c_CW   = $clog2(N);
    localparam logic [c_CW-1:0] c_STEP = c_CW'(STEP);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [N-1:0]    r_w;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_mode;
    logic            r_dir;
    logic [N-1:0]    r_aout;

    logic            w_accept;
    logic [N-1:0]    w_src;
    logic [c_CW-1:0] w_cnt_src;
    logic [1:0]      w_mode;
    logic            w_dir;
    logic [c_CW-1:0] w_k;
    logic [c_CW-1:0] w_cnt_next;
    logic [N-1:0]    w_stepped;
    logic            w_finish;

    // Arithmetic right keeps the MSB, so the sign of the captured A persists.
    function automatic logic [N-1:0] step_fn(
        input logic [N-1:0]    v,
        input logic [c_CW-1:0] k,
        input logic [1:0]      m,
        input logic            d
    );
        logic [N-1:0] r;
        r = v;
        if (m == 2'b10) begin
            if (d) r = (v >> k) | (v << (N - int'(k)));
            else   r = (v << k) | (v >> (N - int'(k)));
        end else if (m != 2'b11) begin
            if (!d)              r = v << k;
            else if (m == 2'b01) r = $signed(v) >>> k;
            else                 r = v >> k;
        end
        return r;
    endfunction

    // A new request is taken from IDLE or DONE; SHIFT ignores start.
    assign w_accept   = bus.start && (r_state != c_SHIFT);
    assign w_src      = w_accept ? bus.A    : r_w;
    assign w_cnt_src  = w_accept ? bus.B    : r_cnt;
    assign w_mode     = w_accept ? bus.mode : r_mode;
    assign w_dir      = w_accept ? bus.dir  : r_dir;
    assign w_k        = (w_cnt_src < c_STEP) ? w_cnt_src : c_STEP;
    assign w_cnt_next = w_cnt_src - w_k;
    assign w_stepped  = step_fn(w_src, w_k, w_mode, w_dir);
    assign w_finish   = (w_cnt_next == '0) || (w_mode == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_SHIFT: w_state_next = w_finish ? c_DONE : c_SHIFT;
            default: begin
                if (w_accept) w_state_next = w_finish ? c_DONE : c_SHIFT;
                else          w_state_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy = (r_state == c_SHIFT);
        bus.done = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w    <= '0;
            r_cnt  <= '0;
            r_mode <= 2'b00;
            r_dir  <= 1'b0;
            r_aout <= '0;
        end else begin
            if (w_accept || (r_state == c_SHIFT)) begin
                r_w   <= w_stepped;
                r_cnt <= w_cnt_next;
            end
            if (w_accept) begin
                r_mode <= bus.mode;
                r_dir  <= bus.dir;
            end
            if (w_state_next == c_DONE) r_aout <= w_stepped;
        end
    end

    assign bus.Aout = r_aout;
endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shifter
// Brief    : Directed checks of seq_shifter in three width/step configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_shifter_if #(.N(8)) if0 ();
    seq_shifter_if #(.N(8)) if1 ();
    seq_shifter_if #(.N(6)) if2 ();

    seq_shifter #(.N(8), .STEP(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    seq_shifter #(.N(8), .STEP(3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    seq_shifter #(.N(6), .STEP(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_aout(input int s);
        case (s)
            0:       return if0.Aout;
            1:       return if1.Aout;
            default: return {2'b00, if2.Aout};
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic get_done(input int s);
        case (s)
            0:       return if0.done;
            1:       return if1.done;
            default: return if2.done;
        endcase
    endfunction

    task automatic set_req(input int s, input logic [7:0] a, input logic [2:0] b,
                           input logic [1:0] m, input logic d, input logic st);
        case (s)
            0: begin if0.A = a; if0.B = b; if0.mode = m; if0.dir = d; if0.start = st; end
            1: begin if1.A = a; if1.B = b; if1.mode = m; if1.dir = d; if1.start = st; end
            default: begin
                if2.A = a[5:0]; if2.B = b; if2.mode = m; if2.dir = d; if2.start = st;
            end
        endcase
    endtask

    task automatic drop_start(input int s);
        case (s)
            0:       if0.start = 1'b0;
            1:       if1.start = 1'b0;
            default: if2.start = 1'b0;
        endcase
    endtask

    task automatic launch(input int s, input logic [7:0] a, input logic [2:0] b,
                          input logic [1:0] m, input logic d);
        @(negedge clk);
        set_req(s, a, b, m, d, 1'b1);
        @(negedge clk);
        drop_start(s);
    endtask

    // Called one negedge after the accepting edge; lat counts edges from acceptance.
    task automatic wait_done(input int s, output logic [7:0] res, output int lat,
                             output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!get_done(s) && lat < 64) begin
            if (get_busy(s)) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!get_done(s)) chk("timeout", 32'(lat), 32'(0));
        res = get_aout(s);
    endtask

    logic [7:0] res;
    int         lat;
    int         bcnt;
    int         ndone;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        set_req(0, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0);
        set_req(1, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0);
        set_req(2, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("reset_aout", 32'(get_aout(s)), 32'h0);
            chk("reset_busy", 32'(get_busy(s)), 32'h0);
            chk("reset_done", 32'(get_done(s)), 32'h0);
        end
        rst = 1'b0;

        launch(0, 8'b1001_0110, 3'd3, 2'b00, 1'b1);
        wait_done(0, res, lat, bcnt);
        chk("lsr3_val", 32'(res), 32'h12);
        chk("lsr3_lat", 32'(lat), 32'd3);
        chk("lsr3_busy", 32'(bcnt), 32'd2);
        repeat (2) @(negedge clk);
        chk("lsr3_hold", 32'(get_aout(0)), 32'h12);
        chk("idle_done", 32'(get_done(0)), 32'h0);

        launch(0, 8'b1001_0110, 3'd3, 2'b01, 1'b1);
        wait_done(0, res, lat, bcnt);
        chk("asr3_val", 32'(res), 32'hF2);
        chk("asr3_lat", 32'(lat), 32'd3);

        // Abort mid-shift: Aout must clear and no done may follow.
        launch(0, 8'hA5, 3'd5, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_aout", 32'(get_aout(0)), 32'h0);
        chk("abort_busy", 32'(get_busy(0)), 32'h0);
        chk("abort_done", 32'(get_done(0)), 32'h0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (get_done(0)) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);

        launch(0, 8'b1001_0110, 3'd3, 2'b00, 1'b1);
        set_req(0, 8'hFF, 3'd1, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        drop_start(0);
        wait_done(0, res, lat, bcnt);
        chk("ignore_val", 32'(res), 32'h12);
        chk("ignore_lat", 32'(lat), 32'd2);

        // Back-to-back: new request presented during the DONE cycle.
        set_req(0, 8'h0F, 3'd4, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        drop_start(0);
        chk("b2b_accept", 32'(get_busy(0)), 32'h1);
        wait_done(0, res, lat, bcnt);
        chk("b2b_val", 32'(res), 32'hF0);
        chk("b2b_lat", 32'(lat), 32'd4);
        @(negedge clk);
        chk("b2b_pulse", 32'(get_done(0)), 32'h0);

        launch(1, 8'h81, 3'd7, 2'b10, 1'b0);
        wait_done(1, res, lat, bcnt);
        chk("rol7_val", 32'(res), 32'hC0);
        chk("rol7_lat", 32'(lat), 32'd3);
        chk("rol7_busy", 32'(bcnt), 32'd2);

        launch(1, 8'h81, 3'd0, 2'b10, 1'b0);
        wait_done(1, res, lat, bcnt);
        chk("b0_val", 32'(res), 32'h81);
        chk("b0_lat", 32'(lat), 32'd1);

        launch(1, 8'h5A, 3'd7, 2'b11, 1'b1);
        wait_done(1, res, lat, bcnt);
        chk("pass_val", 32'(res), 32'h5A);
        chk("pass_lat", 32'(lat), 32'd1);

        launch(2, 8'b0010_0001, 3'd7, 2'b00, 1'b1);
        wait_done(2, res, lat, bcnt);
        chk("n6_lsr_val", 32'(res), 32'h00);
        chk("n6_lsr_lat", 32'(lat), 32'd4);

        launch(2, 8'b0010_0001, 3'd7, 2'b01, 1'b1);
        wait_done(2, res, lat, bcnt);
        chk("n6_asr_val", 32'(res), 32'h3F);
        chk("n6_asr_lat", 32'(lat), 32'd4);

        launch(2, 8'b0010_0001, 3'd7, 2'b10, 1'b1);
        wait_done(2, res, lat, bcnt);
        chk("n6_ror_val", 32'(res), 32'h30);
        chk("n6_ror_lat", 32'(lat), 32'd4);
        chk("n6_ror_busy", 32'(bcnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
